// File: rtl/traffic_phase_seq.sv
// traffic_phase_seq: parametrised traffic-light phase sequencer.
// Steps through NPHASE phases. Each phase has a programmable duration in
// seconds, a light pattern, a blink mask and a walk flag. A run/pause FSM,
// a one-shot skip request with hold time and saturating duration trim are
// included. The timebase comes from an external 1 ms strobe.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   tick_ms              1 ms strobe
//   stop_req             pulse, toggles pause
//   skip_req             level, request advance to next phase
//   plus_req, minus_req  pulses, trim current-phase duration
//   cfg_we/addr/dur/pat/blink/walk   phase configuration write
//   phase, remain, dur_cur           current phase, seconds left, duration
//   lights, walk                     blink-masked pattern, walk flag
//   paused, skip_pending, sec_tick   status and one-cycle second strobe
module traffic_phase_seq #(
    parameter int unsigned NPHASE        = 10,
    parameter int unsigned CW            = 6,
    parameter int unsigned LW            = 10,
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned HOLD_MS       = 1000,
    parameter int unsigned BLINK_MS      = 125,
    parameter int unsigned DEF_DUR       = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_ms,
    input  logic          stop_req,
    input  logic          skip_req,
    input  logic          plus_req,
    input  logic          minus_req,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [CW-1:0] cfg_dur,
    input  logic [LW-1:0] cfg_pat,
    input  logic [LW-1:0] cfg_blink,
    input  logic          cfg_walk,
    output logic [3:0]    phase,
    output logic [CW-1:0] remain,
    output logic [CW-1:0] dur_cur,
    output logic [LW-1:0] lights,
    output logic          walk,
    output logic          paused,
    output logic          skip_pending,
    output logic          sec_tick
);

    localparam int unsigned PW  = (NPHASE > 1) ? $clog2(NPHASE) : 1;
    localparam int unsigned MSW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned HW  = (HOLD_MS > 0) ? $clog2(HOLD_MS + 1) : 1;
    localparam int unsigned BW  = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    localparam logic [CW-1:0] DUR_MAX = '1;
    localparam logic [CW-1:0] DUR_RST = CW'(DEF_DUR);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_PAUSED = 1'b1
    } state_t;

    state_t state_q, state_nxt;

    logic [3:0]        phase_q, phase_nxt;
    logic [CW-1:0]     remain_q, remain_nxt;
    logic [CW-1:0]     dur_q   [NPHASE];
    logic [CW-1:0]     dur_nxt [NPHASE];
    logic [LW-1:0]     pat_q   [NPHASE];
    logic [LW-1:0]     pat_nxt [NPHASE];
    logic [LW-1:0]     blk_q   [NPHASE];
    logic [LW-1:0]     blk_nxt [NPHASE];
    logic [NPHASE-1:0] walk_q, walk_nxt;

    logic [MSW-1:0]    ms_cnt_q, ms_cnt_nxt;
    logic [HW-1:0]     hold_q, hold_nxt;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_nxt;
    logic              blink_off_q, blink_off_nxt;
    logic              skip_req_d_q;
    logic              skip_pending_q, skip_pending_nxt;
    logic              sec_tick_q, sec_tick_nxt;
    logic [LW-1:0]     lights_q, lights_nxt;
    logic              walk_o_q, walk_o_nxt;
    logic [CW-1:0]     dur_cur_q, dur_cur_nxt;
    logic              paused_q, paused_nxt;

    logic              sec_wrap_c;
    logic              advance_c;
    logic              skip_rise_c;
    logic              hold_expire_c;
    logic              cfg_hit_c;
    logic [PW-1:0]     cur_idx_c;
    logic [PW-1:0]     nxt_idx_c;
    logic [PW-1:0]     cfg_idx_c;

    // Next-state computation for timebase, FSM, skip, trim, config and outputs.
    always_comb begin
        state_nxt        = state_q;
        phase_nxt        = phase_q;
        remain_nxt       = remain_q;
        ms_cnt_nxt       = ms_cnt_q;
        hold_nxt         = hold_q;
        blink_cnt_nxt    = blink_cnt_q;
        blink_off_nxt    = blink_off_q;
        skip_pending_nxt = skip_pending_q;
        walk_nxt         = walk_q;
        for (int i = 0; i < NPHASE; i++) begin
            dur_nxt[i] = dur_q[i];
            pat_nxt[i] = pat_q[i];
            blk_nxt[i] = blk_q[i];
        end
        advance_c   = 1'b0;
        cur_idx_c   = PW'(phase_q);
        cfg_idx_c   = PW'(cfg_addr);
        cfg_hit_c   = cfg_we && ({1'b0, cfg_addr} < 5'(NPHASE));
        skip_rise_c = skip_req && !skip_req_d_q;

        // Second timebase; keeps running while paused.
        sec_wrap_c = tick_ms && (ms_cnt_q == MSW'(TICKS_PER_SEC - 1));
        if (tick_ms) begin
            ms_cnt_nxt = sec_wrap_c ? '0 : ms_cnt_q + MSW'(1);
        end
        sec_tick_nxt = sec_wrap_c;

        // Skip hold counter: reload while held, count down after release.
        hold_expire_c = tick_ms && !skip_req && (hold_q == HW'(1));
        if (tick_ms) begin
            if (skip_req) begin
                hold_nxt = HW'(HOLD_MS);
            end else if (hold_q != '0) begin
                hold_nxt = hold_q - HW'(1);
            end
        end

        if (stop_req) begin
            state_nxt = (state_q == S_RUN) ? S_PAUSED : S_RUN;
        end

        // Once-per-second phase update; a pending skip wins even when paused.
        if (sec_wrap_c) begin
            if (skip_pending_q) begin
                advance_c = 1'b1;
            end else if (state_q == S_RUN) begin
                if (remain_q == '0) begin
                    advance_c = 1'b1;
                end else begin
                    remain_nxt = remain_q - CW'(1);
                end
            end
        end
        if (advance_c) begin
            phase_nxt = (phase_q == 4'(NPHASE - 1)) ? 4'd0 : phase_q + 4'd1;
        end
        nxt_idx_c = PW'(phase_nxt);

        // Pending skip is consumed by the advance; re-arms only on a new rising edge.
        if (sec_wrap_c && skip_pending_q) begin
            skip_pending_nxt = 1'b0;
        end else if (hold_expire_c) begin
            skip_pending_nxt = 1'b0;
        end
        if (skip_rise_c) begin
            skip_pending_nxt = 1'b1;
        end

        // Trim of the current phase; a same-cycle config write overrides it.
        if (plus_req && !minus_req && (dur_q[cur_idx_c] != DUR_MAX)) begin
            dur_nxt[cur_idx_c] = dur_q[cur_idx_c] + CW'(1);
        end else if (minus_req && !plus_req && (dur_q[cur_idx_c] != '0)) begin
            dur_nxt[cur_idx_c] = dur_q[cur_idx_c] - CW'(1);
        end
        if (cfg_hit_c) begin
            dur_nxt[cfg_idx_c]  = cfg_dur;
            pat_nxt[cfg_idx_c]  = cfg_pat;
            blk_nxt[cfg_idx_c]  = cfg_blink;
            walk_nxt[cfg_idx_c] = cfg_walk;
        end

        // Load on advance, then clamp against the (possibly trimmed) duration.
        if (advance_c) begin
            remain_nxt = dur_nxt[nxt_idx_c];
        end
        if (dur_nxt[nxt_idx_c] < remain_nxt) begin
            remain_nxt = dur_nxt[nxt_idx_c];
        end

        // Blink restarts in the on half at every phase change.
        if (advance_c) begin
            blink_cnt_nxt = '0;
            blink_off_nxt = 1'b0;
        end else if (tick_ms) begin
            if (blink_cnt_q == BW'(BLINK_MS - 1)) begin
                blink_cnt_nxt = '0;
                blink_off_nxt = !blink_off_q;
            end else begin
                blink_cnt_nxt = blink_cnt_q + BW'(1);
            end
        end

        lights_nxt  = pat_nxt[nxt_idx_c] & ~(blk_nxt[nxt_idx_c] & {LW{blink_off_nxt}});
        walk_o_nxt  = walk_nxt[nxt_idx_c];
        dur_cur_nxt = dur_nxt[nxt_idx_c];
        paused_nxt  = (state_nxt == S_PAUSED);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_RUN;
            phase_q        <= 4'd0;
            remain_q       <= DUR_RST;
            for (int i = 0; i < NPHASE; i++) begin
                dur_q[i] <= DUR_RST;
                pat_q[i] <= '0;
                blk_q[i] <= '0;
            end
            walk_q         <= '0;
            ms_cnt_q       <= '0;
            hold_q         <= '0;
            blink_cnt_q    <= '0;
            blink_off_q    <= 1'b0;
            skip_req_d_q   <= 1'b0;
            skip_pending_q <= 1'b0;
            sec_tick_q     <= 1'b0;
            lights_q       <= '0;
            walk_o_q       <= 1'b0;
            dur_cur_q      <= DUR_RST;
            paused_q       <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            phase_q        <= phase_nxt;
            remain_q       <= remain_nxt;
            for (int i = 0; i < NPHASE; i++) begin
                dur_q[i] <= dur_nxt[i];
                pat_q[i] <= pat_nxt[i];
                blk_q[i] <= blk_nxt[i];
            end
            walk_q         <= walk_nxt;
            ms_cnt_q       <= ms_cnt_nxt;
            hold_q         <= hold_nxt;
            blink_cnt_q    <= blink_cnt_nxt;
            blink_off_q    <= blink_off_nxt;
            skip_req_d_q   <= skip_req;
            skip_pending_q <= skip_pending_nxt;
            sec_tick_q     <= sec_tick_nxt;
            lights_q       <= lights_nxt;
            walk_o_q       <= walk_o_nxt;
            dur_cur_q      <= dur_cur_nxt;
            paused_q       <= paused_nxt;
        end
    end

    assign phase        = phase_q;
    assign remain       = remain_q;
    assign dur_cur      = dur_cur_q;
    assign lights       = lights_q;
    assign walk         = walk_o_q;
    assign paused       = paused_q;
    assign skip_pending = skip_pending_q;
    assign sec_tick     = sec_tick_q;

endmodule

// File: doc/traffic_phase_seq.md
# traffic_phase_seq

Parametrised successor to the fixed ten-mode traffic controller. It sequences NPHASE phases, each with a programmable duration in seconds, a light pattern, a per-bit blink mask and a walk flag. It supports run-time pause, a one-shot skip request with hold time, and saturating plus/minus duration trimming. It sits between the board-level pulse generators and debouncers and the light, 7-segment and walk-sign drivers, and consumes an external 1 ms strobe instead of deriving its own dividers.

## Interface
Parameters:
- NPHASE, 10, number of phases (2..16)
- CW, 6, duration/remaining counter width
- LW, 10, light-pattern width
- TICKS_PER_SEC, 1000, tick_ms strobes per second
- HOLD_MS, 1000, skip hold time in ms
- BLINK_MS, 125, blink half-period in ms
- DEF_DUR, 15, reset duration of every phase

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick_ms  in  1  one-cycle strobe, once per ms
- stop_req  in  1  one-cycle pulse; toggles pause
- skip_req  in  1  level; request advance to next phase
- plus_req / minus_req  in  1  one-cycle pulses; trim current-phase duration
- cfg_we  in  1  write phase config
- cfg_addr  in  4  phase to write
- cfg_dur  in  CW  duration
- cfg_pat  in  LW  light pattern
- cfg_blink  in  LW  blink mask
- cfg_walk  in  1  walk flag
- phase  out  4  current phase index
- remain  out  CW  seconds remaining in phase
- dur_cur  out  CW  programmed duration of current phase
- lights  out  LW  masked light pattern
- walk  out  1  walk flag of current phase
- paused  out  1  pause state
- skip_pending  out  1  skip armed
- sec_tick  out  1  one-cycle strobe per second

## Operation
- Reset:
  - phase=0, remain=DEF_DUR, paused=0, skip_pending=0, sec_tick=0.
  - All durations = DEF_DUR; all patterns, masks and walk flags = 0; hence lights=0 and walk=0.
  - ms counter, hold counter and blink counter = 0; blink phase = on.
- Second timebase:
  - ms counter counts tick_ms 0..TICKS_PER_SEC-1 and wraps.
  - sec_tick pulses on the wrapping tick.
  - The counter keeps running while paused.
- Phase FSM (RUN/PAUSED, paused output). On each sec_tick, in priority order:
  - skip_pending=1: advance and clear skip_pending. This applies in RUN and PAUSED.
  - PAUSED: hold phase and remain.
  - remain==0: advance.
  - otherwise: remain-1.
- Advance:
  - phase = (phase==NPHASE-1) ? 0 : phase+1.
  - remain = dur[new phase].
  - A phase therefore lasts dur+1 seconds; dur=0 gives 1 s.
- stop_req toggles paused. It does not change phase or remain.
- Skip:
  - While skip_req=1, the hold counter reloads to HOLD_MS on each tick_ms.
  - While skip_req=0, the hold counter decrements per tick_ms down to 0.
  - skip_pending = 1 from the first cycle skip_req is high until the hold counter reaches 0, or until an advance consumes it.
  - After consumption, skip_pending re-arms only on a new rising edge of skip_req. Exactly one advance per request.
- Trim:
  - plus_req: dur[phase]+1, saturating at 2^CW-1.
  - minus_req: dur[phase]-1, saturating at 0.
  - Both in the same cycle: no change.
  - If the new duration is below remain, remain clamps to the new duration in the same update.
- Config write:
  - cfg_we writes all four fields at cfg_addr; cfg_addr ≥ NPHASE is ignored.
  - cfg_we to the current phase in the same cycle as a trim: cfg_we wins, and the remain clamp uses cfg_dur.
  - Writing the current phase does not reload remain (clamp only).
- Blink:
  - Blink counter counts tick_ms and toggles blink phase every BLINK_MS ms.
  - Blink counter and blink phase are forced to 0/on on every advance.
  - lights = pat[phase] & ~(blink[phase] & {LW{off}}).
  - walk = walk[phase].

## Timing
- All outputs are registered.
- sec_tick is asserted the cycle after the wrapping tick_ms.
- phase and remain update the cycle after the tick_ms that causes sec_tick.
- lights and walk follow phase in that same cycle.
- Trim, stop and cfg effects are visible one cycle after the request.
- skip_pending rises one cycle after skip_req rises.
- rst asserted mid-operation returns every output to its reset value on the next edge, overriding all requests.
- Simultaneous sec_tick and trim: the sec_tick update runs first, then the clamp against the trimmed duration.

## Test plan
- Reset with TICKS_PER_SEC=4, DEF_DUR=2, no inputs -> phase advances every 12 tick_ms (3 s); NPHASE-1 wraps to 0.
- Pause at remain=1, then 5 s of ticks -> remain stays 1 and paused=1; second stop_req -> countdown resumes.
- skip_req high 3 s while running at remain=10 -> exactly one advance at the next sec_tick; skip_pending=0 afterwards despite skip_req still high.
- Duration 63 (CW=6) + plus_req -> stays 63; duration 0 + minus_req -> stays 0; remain=5, dur trimmed to 3 -> remain=3.
- cfg_pat=10'h3FF, cfg_blink=10'h00F, BLINK_MS=2 -> low nibble toggles every 2 tick_ms, high bits steady; blink restarts on (low nibble on) at phase change.
- rst during a PAUSED phase 4 with skip pending -> phase=0, remain=DEF_DUR, paused=0, skip_pending=0 next cycle.
